// File: rtl/mult_arb.sv
// Two-requester round-robin front end for a shared, in-order pipelined multiplier.
// Issued requester IDs are kept in a tag FIFO so each result returns to its owner.
module mult_arb #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [127:0] req_mcand,
    input  logic [127:0] req_mplier,
    output logic [1:0]   resp_valid,
    output logic [63:0]  resp_product,
    output logic         mult_start,
    output logic [63:0]  mult_mcand,
    output logic [63:0]  mult_mplier,
    input  logic [63:0]  mult_product,
    input  logic         mult_done,
    output logic [3:0]   inflight,
    output logic         err
);
    localparam int            PW   = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam logic [3:0]    FULL = 4'(MAX_INFLIGHT);
    localparam logic [PW-1:0] LAST = PW'(MAX_INFLIGHT - 1);

    logic          r_live;
    logic          r_ptr;
    logic          r_start;
    logic          r_err;
    logic [63:0]   r_mcand;
    logic [63:0]   r_mplier;
    logic [63:0]   r_resp_product;
    logic [1:0]    r_resp_valid;
    logic [3:0]    r_inflight;
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic          r_tag [MAX_INFLIGHT];

    logic [1:0]    w_grant;
    logic          w_win;
    logic          w_xfer;
    logic          w_empty;
    logic          w_pop;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // r_live stays low through the first edge after reset release, so no transfer can land there.
    always_comb begin
        w_grant = '0;
        if (r_live && (r_inflight != FULL)) begin
            if (req_valid[r_ptr])
                w_grant[r_ptr] = 1'b1;
            else if (req_valid[~r_ptr])
                w_grant[~r_ptr] = 1'b1;
        end
    end

    assign req_ready = w_grant;
    assign w_xfer    = |(req_valid & w_grant);
    assign w_win     = w_grant[1];
    assign w_empty   = (r_inflight == '0);
    assign w_pop     = mult_done && !w_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_live         <= 1'b0;
            r_ptr          <= 1'b0;
            r_start        <= 1'b0;
            r_err          <= 1'b0;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_resp_product <= '0;
            r_resp_valid   <= '0;
            r_inflight     <= '0;
            r_wp           <= '0;
            r_rp           <= '0;
            for (int unsigned i = 0; i < MAX_INFLIGHT; i++)
                r_tag[i] <= 1'b0;
        end else begin
            r_live       <= 1'b1;
            r_start      <= w_xfer;
            r_resp_valid <= '0;
            if (w_xfer) begin
                r_mcand     <= w_win ? req_mcand[127:64]  : req_mcand[63:0];
                r_mplier    <= w_win ? req_mplier[127:64] : req_mplier[63:0];
                r_tag[r_wp] <= w_win;
                r_wp        <= f_next(r_wp);
                r_ptr       <= ~w_win;
            end
            if (w_pop) begin
                r_resp_valid   <= r_tag[r_rp] ? 2'b10 : 2'b01;
                r_resp_product <= mult_product;
                r_rp           <= f_next(r_rp);
            end
            if (mult_done && w_empty)
                r_err <= 1'b1;
            case ({w_xfer, w_pop})
                2'b10:   r_inflight <= r_inflight + 4'd1;
                2'b01:   r_inflight <= r_inflight - 4'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_product = r_resp_product;
    assign mult_start   = r_start;
    assign mult_mcand   = r_mcand;
    assign mult_mplier  = r_mplier;
    assign inflight     = r_inflight;
    assign err          = r_err;

endmodule
